// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word geometry, PC step and the boot loader state type.
package cpu_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] ADDR_STEP = 32'd4;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StCheck = 3'd2,
    StDone  = 3'd3,
    StError = 3'd4
  } loader_state_t;

  // A load length is usable only if it is non-zero and fits the memory.
  function automatic logic len_is_legal(input int unsigned len, input int unsigned depth);
    return (len != 0) && (len <= depth);
  endfunction

endpackage

// File: rtl/loader_checksum.sv
// Running 32-bit additive checksum; one add per enabled cycle, wraps mod 2^32.
module loader_checksum
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] sum
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + din;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams instruction words into IMEM at PC+4 steps, verifies the checksum, then releases the CPU.
module imem_boot_loader
  import cpu_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 256,
  parameter logic [WORD_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned       LEN_W       = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  load_len,
  input  logic [WORD_W-1:0] exp_sum,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [WORD_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic [LEN_W-1:0]  words_loaded,
  output logic              done,
  output logic              error,
  output logic              cpu_run
);

  loader_state_t     state;
  logic [LEN_W-1:0]  len;
  logic [WORD_W-1:0] exp_val;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] sum;
  logic              start_ok;
  logic              xfer;
  logic              last_word;

  assign start_ok  = start && (state inside {StIdle, StDone, StError});
  assign xfer      = (state == StLoad) && in_valid && in_ready;
  assign last_word = (words_loaded + LEN_W'(1)) == len;
  assign cpu_run   = done;

  loader_checksum u_checksum (
    .clk   (clk),
    .rst   (rst),
    .clear (start_ok),
    .en    (xfer),
    .din   (in_data),
    .sum   (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_wdata   <= '0;
      words_loaded <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      len          <= '0;
      exp_val      <= '0;
      addr         <= BASE_ADDR;
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        StIdle, StDone, StError: begin
          if (start_ok) begin
            len          <= load_len;
            exp_val      <= exp_sum;
            words_loaded <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
            addr         <= BASE_ADDR;
            if (len_is_legal(32'(load_len), DEPTH_WORDS)) begin
              state    <= StLoad;
              in_ready <= 1'b1;
            end else begin
              state <= StError;
              error <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (xfer) begin
            imem_we      <= 1'b1;
            imem_wdata   <= in_data;
            imem_addr    <= addr;
            addr         <= addr + ADDR_STEP;
            words_loaded <= words_loaded + LEN_W'(1);
            // Drop ready on the final word so the stream cannot overrun len.
            if (last_word) begin
              in_ready <= 1'b0;
              state    <= StCheck;
            end
          end
        end
        StCheck: begin
          if (sum == exp_val) begin
            state <= StDone;
            done  <= 1'b1;
          end else begin
            state <= StError;
            error <= 1'b1;
          end
        end
        default: begin
          state    <= StIdle;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

  a_addr_aligned: assert property (@(posedge clk) disable iff (rst)
    imem_we |-> (imem_addr[1:0] == 2'b00));

  a_done_error_excl: assert property (@(posedge clk) disable iff (rst)
    !(done && error));

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized scoreboard bench for imem_boot_loader.
module tb_imem_boot_loader;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = 5;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] load_len;
  logic [31:0]   exp_sum;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_ready;
  logic          imem_we;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_wdata;
  logic [LW-1:0] words_loaded;
  logic          done;
  logic          error;
  logic          cpu_run;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] words_q[$];
  logic [31:0] last_addr;
  int          vectors     = 0;
  int          miscompares = 0;

  imem_boot_loader #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .LEN_W       (LW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .load_len     (load_len),
    .exp_sum      (exp_sum),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .words_loaded (words_loaded),
    .done         (done),
    .error        (error),
    .cpu_run      (cpu_run)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr %h data %h, want no write",
                 imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (imem_addr !== mon_e.addr || imem_wdata !== mon_e.data) begin
          miscompares++;
          $display("FAIL write: got addr %h data %h, want addr %h data %h",
                   imem_addr, imem_wdata, mon_e.addr, mon_e.data);
        end
        last_addr = imem_addr;
      end
    end
  end

  function automatic logic [31:0] sum_words();
    logic [31:0] s = '0;
    foreach (words_q[i]) s += words_q[i];
    return s;
  endfunction

  task automatic fill_random(input int n);
    words_q.delete();
    for (int i = 0; i < n; i++) words_q.push_back($urandom);
  endtask

  // Start pulse with a junk word offered at the same time; it must be ignored.
  task automatic do_start(input int len, input logic [31:0] e);
    @(negedge clk);
    start    = 1'b1;
    load_len = LW'(len);
    exp_sum  = e;
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  // Returns at the negedge just before the posedge that performs the transfer.
  task automatic send_word(input logic [31:0] d, input int gaps, output bit ok);
    int g;
    repeat (gaps) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    ok = in_ready;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: got in_ready 0 for 50 cycles, want 1");
    end
  endtask

  task automatic run_load(input int len, input logic [31:0] e, input int gap_fixed,
                          input int gap_rand, input bit overrun);
    logic [31:0] s;
    bit          ok;
    wr_t         w;
    s = '0;
    do_start(len, e);
    for (int i = 0; i < len; i++) begin
      send_word(words_q[i], (i == 0) ? 0 : gap_fixed + int'($urandom_range(gap_rand, 0)), ok);
      if (!ok) begin
        in_valid = 1'b0;
        exp_q.delete();
        return;
      end
      w.addr = BASE + 32'(4 * i);
      w.data = words_q[i];
      exp_q.push_back(w);
      s += words_q[i];
    end
    @(negedge clk);
    if (overrun) begin
      in_valid = 1'b1;
      in_data  = $urandom;
    end else begin
      in_valid = 1'b0;
    end
    check("in_ready_after_last", 32'(in_ready), 32'd0);
    check("words_loaded", 32'(words_loaded), 32'(len));
    check("done_during_check", 32'(done), 32'd0);
    @(negedge clk);
    check("done", 32'(done), 32'(s == e));
    check("error", 32'(error), 32'(s != e));
    check("cpu_run", 32'(cpu_run), 32'(s == e));
    if (overrun) begin
      repeat (3) begin
        @(negedge clk);
        check("in_ready_overrun", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
    end
    @(negedge clk);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit ok;
    rst      = 1'b1;
    start    = 1'b0;
    load_len = '0;
    exp_sum  = '0;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    check("rst_imem_addr", imem_addr, BASE);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_words_loaded", 32'(words_loaded), 32'd0);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("idle_in_ready", 32'(in_ready), 32'd0);
    end

    // Nominal load
    words_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_load(4, 32'h0000_000A, 0, 0, 1'b0);

    // Bubbles then overrun attempt
    fill_random(3);
    run_load(3, sum_words(), 1, 0, 1'b1);

    // Checksum wrap mismatch, then match
    words_q = '{32'hFFFF_FFFF, 32'h0000_0002};
    run_load(2, 32'h0, 0, 0, 1'b0);
    run_load(2, 32'h1, 0, 0, 1'b0);

    // Bad lengths
    do_start(0, 32'h0);
    check("len0_error", 32'(error), 32'd1);
    check("len0_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    do_start(DEPTH + 1, 32'h0);
    check("lenbig_error", 32'(error), 32'd1);
    check("lenbig_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);

    // Full-depth load
    fill_random(DEPTH);
    run_load(DEPTH, sum_words(), 0, 1, 1'b0);
    check("full_last_addr", last_addr, BASE + 32'(4 * (DEPTH - 1)));

    // Reset mid-load
    fill_random(8);
    do_start(8, sum_words());
    for (int i = 0; i < 3; i++) begin
      wr_t w;
      send_word(words_q[i], 0, ok);
      w.addr = BASE + 32'(4 * i);
      w.data = words_q[i];
      if (ok) exp_q.push_back(w);
    end
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_words_loaded", 32'(words_loaded), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_imem_addr", imem_addr, BASE);
    repeat (5) @(negedge clk);
    check("midrst_pending", 32'(exp_q.size()), 32'd0);
    fill_random(5);
    run_load(5, sum_words(), 0, 2, 1'b0);

    // Randomized loads, about half with a corrupted expected sum
    for (int n = 0; n < 8; n++) begin
      int l;
      l = int'($urandom_range(DEPTH, 1));
      fill_random(l);
      run_load(l, sum_words() + (($urandom_range(1, 0) == 1) ? 32'd1 : 32'd0),
               0, 2, 1'($urandom_range(1, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
